ft232h_traffic_gen: RTL and testbench

//  Parametrised Avalon-MM master traffic generator/checker for the ft232h FIFO core, running on sysclk.
//  TX: writes a selectable pattern (counter, LFSR or constant) to the core's TX register.
//  RX: reads the RX register and compares each word against an identically seeded expected pattern.

---
 rtl/ft232h_traffic_gen_pkg.sv | 32 +++
 rtl/ft232h_pattern_gen.sv | 48 ++++
 rtl/ft232h_traffic_gen.sv | 157 +++++++++++++++
 tb/tb_ft232h_traffic_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ft232h_traffic_gen_pkg.sv
// rtl/ft232h_traffic_gen_pkg.sv - shared encodings and LFSR taps for the ft232h traffic generator
`timescale 1ns/1ps
package ft232h_traffic_gen_pkg;

  typedef enum logic [1:0] {
    PAT_CNT   = 2'd0,
    PAT_LFSR  = 2'd1,
    PAT_CONST = 2'd2,
    PAT_RSVD  = 2'd3
  } pattern_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // Right-shifting Galois masks giving maximal-length sequences.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      16:      return LFSR_TAPS_16;
      32:      return LFSR_TAPS_32;
      default: return LFSR_TAPS_8;
    endcase
  endfunction

endpackage

// File: rtl/ft232h_pattern_gen.sv
// rtl/ft232h_pattern_gen.sv - counter / LFSR / constant payload source
`timescale 1ns/1ps
module ft232h_pattern_gen
  import ft232h_traffic_gen_pkg::*;
#(
  parameter int          PAYLOAD_W = 8,
  parameter int          SEED      = 1,
  parameter logic [31:0] CONST_VAL = 32'hA5
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [1:0]           sel,
  output logic [PAYLOAD_W-1:0] value
);

  localparam logic [31:0]          TAPS_FULL = lfsr_taps(PAYLOAD_W);
  localparam logic [PAYLOAD_W-1:0] TAPS      = TAPS_FULL[PAYLOAD_W-1:0];
  localparam logic [PAYLOAD_W-1:0] SEED_V    = PAYLOAD_W'(SEED);
  localparam logic [PAYLOAD_W-1:0] CONST_V   = CONST_VAL[PAYLOAD_W-1:0];

  logic [PAYLOAD_W-1:0] cnt;
  logic [PAYLOAD_W-1:0] lfsr;

  // Both sequences run together so sel only picks which one is presented.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      lfsr <= SEED_V;
    end else if (load) begin
      cnt  <= '0;
      lfsr <= SEED_V;
    end else if (step) begin
      cnt  <= cnt + PAYLOAD_W'(1);
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    end
  end

  always_comb begin
    case (sel)
      PAT_LFSR:  value = lfsr;
      PAT_CONST: value = CONST_V;
      default:   value = cnt;
    endcase
  end

endmodule

// File: rtl/ft232h_traffic_gen.sv
// rtl/ft232h_traffic_gen.sv - Avalon-MM write/read-check traffic generator for the ft232h FIFO core
`timescale 1ns/1ps
module ft232h_traffic_gen
  import ft232h_traffic_gen_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          PAYLOAD_W = 8,
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  TX_ADDR   = 8'h01,
  parameter logic [7:0]  RX_ADDR   = 8'h00,
  parameter int          SEED      = 1,
  parameter logic [31:0] CONST_VAL = 32'hA5,
  parameter int          CNT_W     = 32
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 tx_en,
  input  logic                 rx_en,
  input  logic [1:0]           pattern_sel,
  input  logic [15:0]          burst_len,
  output logic [ADDR_W-1:0]    avm_address,
  output logic                 avm_read,
  output logic                 avm_write,
  output logic [DATA_W-1:0]    avm_writedata,
  input  logic [DATA_W-1:0]    avm_readdata,
  input  logic                 avm_waitrequest,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     tx_count,
  output logic [CNT_W-1:0]     rx_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [PAYLOAD_W-1:0] first_err
);

  state_t               state, state_nxt;
  logic                 gap;
  logic                 stop_pend;
  logic [1:0]           sel_r;
  logic [15:0]          blen_r;
  logic                 tx_en_r, rx_en_r;
  logic                 accept;
  logic                 wr_cpl, rd_cpl;
  logic                 cont, tx_more, rx_more;
  logic [PAYLOAD_W-1:0] tx_val, rx_exp, rx_pay;

  assign cont    = (blen_r == 16'd0);
  assign tx_more = tx_en_r && (cont || tx_count != CNT_W'(blen_r));
  assign rx_more = rx_en_r && (cont || rx_count != CNT_W'(blen_r));

  // Strobes are derived from registered state so an async reset drops them at once.
  assign avm_write     = (state == S_WR) && !gap;
  assign avm_read      = (state == S_RD) && !gap;
  assign avm_address   = (state == S_RD) ? ADDR_W'(RX_ADDR) : ADDR_W'(TX_ADDR);
  assign avm_writedata = avm_write ? DATA_W'(tx_val) : '0;
  assign wr_cpl        = avm_write && !avm_waitrequest;
  assign rd_cpl        = avm_read && !avm_waitrequest;
  assign rx_pay        = avm_readdata[PAYLOAD_W-1:0];

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Direction and termination are decided in the idle cycle after each completion.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (tx_en || rx_en) begin
            accept    = 1'b1;
            state_nxt = tx_en ? S_WR : S_RD;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_WR, S_RD: begin
        if (gap) begin
          if ((cont && (stop_pend || stop)) || !(tx_more || rx_more)) state_nxt = S_DONE;
          else if (state == S_WR) state_nxt = rx_more ? S_RD : S_WR;
          else                    state_nxt = tx_more ? S_WR : S_RD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      gap       <= 1'b0;
      stop_pend <= 1'b0;
      sel_r     <= 2'd0;
      blen_r    <= 16'd0;
      tx_en_r   <= 1'b0;
      rx_en_r   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tx_count  <= '0;
      rx_count  <= '0;
      err_count <= '0;
      first_err <= '0;
    end else begin
      gap <= wr_cpl || rd_cpl;
      if (accept) begin
        sel_r     <= pattern_sel;
        blen_r    <= burst_len;
        tx_en_r   <= tx_en;
        rx_en_r   <= rx_en;
        stop_pend <= 1'b0;
        busy      <= 1'b1;
        done      <= 1'b0;
        tx_count  <= '0;
        rx_count  <= '0;
        err_count <= '0;
        first_err <= '0;
      end else if (state == S_IDLE && start) begin
        done <= 1'b0;
      end
      if ((state == S_WR || state == S_RD) && cont && stop) stop_pend <= 1'b1;
      if (wr_cpl) tx_count <= tx_count + CNT_W'(1);
      if (rd_cpl) begin
        rx_count <= rx_count + CNT_W'(1);
        if (rx_pay != rx_exp) begin
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
          if (err_count == '0) first_err <= rx_pay;
        end
      end
      if (state == S_DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  ft232h_pattern_gen #(.PAYLOAD_W(PAYLOAD_W), .SEED(SEED), .CONST_VAL(CONST_VAL)) u_tx_gen (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (wr_cpl),
    .sel    (sel_r),
    .value  (tx_val)
  );

  ft232h_pattern_gen #(.PAYLOAD_W(PAYLOAD_W), .SEED(SEED), .CONST_VAL(CONST_VAL)) u_rx_gen (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (rd_cpl),
    .sel    (sel_r),
    .value  (rx_exp)
  );

endmodule

// File: tb/tb_ft232h_traffic_gen.sv
// tb/tb_ft232h_traffic_gen.sv - scoreboard bench for ft232h_traffic_gen
`timescale 1ns/1ps
module tb_ft232h_traffic_gen;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } xact_t;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        stop   = 1'b0;
  logic        tx_en  = 1'b0;
  logic        rx_en  = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] burst_len   = 16'd0;
  logic [7:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata    = 32'd0;
  logic        avm_waitrequest = 1'b0;
  logic        busy, done;
  logic [31:0] tx_count, rx_count, err_count;
  logic [7:0]  first_err;

  int passed = 0;
  int total  = 0;

  xact_t       exp_q[$];
  xact_t       act_q[$];
  logic [31:0] rd_q[$];
  int          stall_left = 0;
  int          stall_seen = 0;
  int          unstable   = 0;
  xact_t       snap;
  bit          snap_valid = 0;

  ft232h_traffic_gen dut (
    .sysclk          (sysclk),
    .rst_n           (rst_n),
    .start           (start),
    .stop            (stop),
    .tx_en           (tx_en),
    .rx_en           (rx_en),
    .pattern_sel     (pattern_sel),
    .burst_len       (burst_len),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .tx_count        (tx_count),
    .rx_count        (rx_count),
    .err_count       (err_count),
    .first_err       (first_err)
  );

  always #5 sysclk = ~sysclk;

  // Slave model: decides waitrequest/readdata for the coming edge and logs completions.
  always @(negedge sysclk) begin
    if (avm_read || avm_write) begin
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
        stall_seen++;
        if (!snap_valid) begin
          snap.wr = avm_write; snap.addr = avm_address; snap.data = avm_writedata;
          snap_valid = 1;
        end else if (snap.wr !== avm_write || snap.addr !== avm_address || snap.data !== avm_writedata) begin
          unstable++;
        end
      end else begin
        xact_t x;
        avm_waitrequest = 1'b0;
        snap_valid = 0;
        x.wr   = avm_write;
        x.addr = avm_address;
        if (avm_read) begin
          avm_readdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'd0;
          x.data = avm_readdata;
        end else begin
          x.data = avm_writedata;
        end
        act_q.push_back(x);
      end
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  task automatic push_exp(input bit wr, input logic [7:0] addr, input logic [31:0] data);
    xact_t x;
    x.wr = wr; x.addr = addr; x.data = data;
    exp_q.push_back(x);
  endtask

  task automatic start_run(input bit t, input bit r, input logic [1:0] sel, input logic [15:0] blen);
    @(negedge sysclk);
    tx_en = t; rx_en = r; pattern_sel = sel; burst_len = blen;
    exp_q.delete(); act_q.delete();
    start = 1'b1;
    @(posedge sysclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge sysclk);
      n++;
    end
    total++;
    if (done !== 1'b1) $display("FAIL %s done_timeout: done=%b required 1", name, done);
    else passed++;
  endtask

  task automatic check_stream(input string name);
    total++;
    if (act_q.size() !== exp_q.size())
      $display("FAIL %s xact_count: got %0d required %0d", name, act_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      xact_t e, a;
      e = exp_q.pop_front();
      a = act_q.pop_front();
      total++;
      if (a.wr !== e.wr || a.addr !== e.addr || a.data !== e.data)
        $display("FAIL %s xact: got wr=%0d addr=%h data=%h required wr=%0d addr=%h data=%h",
                 name, a.wr, a.addr, a.data, e.wr, e.addr, e.data);
      else passed++;
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) $display("FAIL %s: got %h required %h", name, got, req);
    else passed++;
  endtask

  task automatic test_reset;
    check_val("reset_write", {31'd0, avm_write}, 32'd0);
    check_val("reset_read", {31'd0, avm_read}, 32'd0);
    check_val("reset_addr", {24'd0, avm_address}, 32'h01);
    check_val("reset_wdata", avm_writedata, 32'd0);
    check_val("reset_busy_done", {30'd0, busy, done}, 32'd0);
    check_val("reset_counts", tx_count | rx_count | err_count, 32'd0);
    check_val("reset_first_err", {24'd0, first_err}, 32'd0);
  endtask

  task automatic test_tx_counter;
    start_run(1, 0, 2'd0, 16'd4);
    for (int i = 0; i < 4; i++) push_exp(1, 8'h01, i);
    wait_done("tx_counter");
    check_stream("tx_counter");
    check_val("tx_counter_tx_count", tx_count, 32'd4);
    check_val("tx_counter_rx_count", rx_count, 32'd0);
    check_val("tx_counter_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_waitrequest;
    stall_seen = 0; unstable = 0; stall_left = 5;
    start_run(1, 0, 2'd0, 16'd2);
    push_exp(1, 8'h01, 32'd0);
    push_exp(1, 8'h01, 32'd1);
    wait_done("waitreq");
    check_stream("waitreq");
    check_val("waitreq_stall_cycles", stall_seen, 32'd5);
    check_val("waitreq_unstable", unstable, 32'd0);
    check_val("waitreq_tx_count", tx_count, 32'd2);
  endtask

  task automatic test_rx_lfsr;
    rd_q.delete();
    rd_q.push_back(32'h01); rd_q.push_back(32'hB8); rd_q.push_back(32'h00);
    start_run(0, 1, 2'd1, 16'd3);
    push_exp(0, 8'h00, 32'h01);
    push_exp(0, 8'h00, 32'hB8);
    push_exp(0, 8'h00, 32'h00);
    wait_done("rx_lfsr");
    check_stream("rx_lfsr");
    check_val("rx_lfsr_rx_count", rx_count, 32'd3);
    check_val("rx_lfsr_err_count", err_count, 32'd1);
    check_val("rx_lfsr_first_err", {24'd0, first_err}, 32'h00);
  endtask

  task automatic test_both_const;
    rd_q.delete();
    rd_q.push_back(32'hA5); rd_q.push_back(32'hA5);
    start_run(1, 1, 2'd2, 16'd2);
    push_exp(1, 8'h01, 32'hA5); push_exp(0, 8'h00, 32'hA5);
    push_exp(1, 8'h01, 32'hA5); push_exp(0, 8'h00, 32'hA5);
    wait_done("both_const");
    check_stream("both_const");
    check_val("both_const_tx_count", tx_count, 32'd2);
    check_val("both_const_rx_count", rx_count, 32'd2);
    check_val("both_const_err_count", err_count, 32'd0);
  endtask

  task automatic test_stop_continuous;
    int n = 0;
    start_run(1, 0, 2'd0, 16'd0);
    while (act_q.size() < 3 && n < 200) begin @(negedge sysclk); n++; end
    stall_left = 4;
    n = 0;
    do begin @(negedge sysclk); #1; n++; end while (!avm_waitrequest && n < 200);
    stop = 1'b1;
    @(posedge sysclk); #1;
    stop = 1'b0;
    wait_done("stop");
    for (int i = 0; i < act_q.size(); i++) push_exp(1, 8'h01, i);
    check_val("stop_tx_count", tx_count, act_q.size());
    check_val("stop_no_pending_stall", stall_left, 32'd0);
    check_stream("stop");
  endtask

  task automatic test_reset_mid;
    stall_left = 0;
    start_run(1, 0, 2'd0, 16'd10);
    while (act_q.size() < 3) @(negedge sysclk);
    @(posedge sysclk); #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_strobes", {30'd0, avm_write, avm_read}, 32'd0);
    check_val("rst_mid_counts", tx_count | rx_count | err_count, 32'd0);
    check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(negedge sysclk);
    rst_n = 1'b1;
    start_run(1, 0, 2'd1, 16'd2);
    push_exp(1, 8'h01, 32'h01);
    push_exp(1, 8'h01, 32'hB8);
    wait_done("rst_restart");
    check_stream("rst_restart");
    check_val("rst_restart_tx_count", tx_count, 32'd2);
  endtask

  initial begin
    repeat (3) @(posedge sysclk);
    #1;
    test_reset;
    @(negedge sysclk);
    rst_n = 1'b1;
    test_tx_counter;
    test_waitrequest;
    test_rx_lfsr;
    test_both_const;
    test_stop_continuous;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
